// File: rtl/screening_pkg.sv
// Shared types for the sequential bit screener: per-word order select and iterator state.
package screening_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 8;

  typedef enum logic {
    SCREEN_JUNIOR = 1'b0,
    SCREEN_SENIOR = 1'b1
  } screen_mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_ITER
  } screen_iter_state_t;

endpackage

// File: rtl/onehot_to_index.sv
// One-hot to binary encoder; a zero input encodes to index 0.
module onehot_to_index #(
  parameter int unsigned WORD_WIDTH = 8,
  localparam int unsigned INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0]  i_onehot,
  output logic [INDEX_WIDTH-1:0] o_index
);

  always_comb begin
    o_index = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (i_onehot[i]) begin
        o_index = o_index | INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/screening_by_junior.sv
// Combinational junior screen: isolates the lowest set bit of in_word when c_i is high.
module screening_by_junior #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  c_i,
  input  logic [WORD_WIDTH-1:0] in_word,
  output logic [WORD_WIDTH-1:0] out_onehot
);

  // Two's-complement trick: x & -x keeps only the lowest set bit.
  assign out_onehot = c_i ? (in_word & (~in_word + WORD_WIDTH'(1))) : '0;

endmodule

// File: rtl/screening_by_senior.sv
// Combinational senior screen: isolates the highest set bit of in_word when c_i is high.
module screening_by_senior #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  c_i,
  input  logic [WORD_WIDTH-1:0] in_word,
  output logic [WORD_WIDTH-1:0] out_onehot
);

  // Ascending scan; each later hit overwrites, so the highest set bit wins.
  always_comb begin
    out_onehot = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (c_i && in_word[i]) begin
        out_onehot    = '0;
        out_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/screening_iterator.sv
// Accepts a word via valid/ready and emits its set bits one per beat, junior- or senior-first.
module screening_iterator
  import screening_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
  localparam int unsigned INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  in_word,
  input  logic                   in_mode,
  input  logic                   c_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_onehot,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   out_empty
);

  screen_iter_state_t r_state;
  screen_mode_t       r_mode;
  logic [WORD_WIDTH-1:0] r_remaining;

  logic [WORD_WIDTH-1:0]  w_junior;
  logic [WORD_WIDTH-1:0]  w_senior;
  logic [WORD_WIDTH-1:0]  w_pick;
  logic [INDEX_WIDTH-1:0] w_index;
  logic                   w_iter;
  logic                   w_last;
  logic                   w_beat;
  logic                   w_accept;

  screening_by_junior #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_junior (
    .c_i        (1'b1),
    .in_word    (r_remaining),
    .out_onehot (w_junior)
  );

  screening_by_senior #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_senior (
    .c_i        (1'b1),
    .in_word    (r_remaining),
    .out_onehot (w_senior)
  );

  assign w_pick = (r_mode == SCREEN_SENIOR) ? w_senior : w_junior;

  onehot_to_index #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_encode (
    .i_onehot (w_pick),
    .o_index  (w_index)
  );

  assign w_iter   = (r_state == ST_ITER);
  assign w_last   = ((r_remaining & ~w_pick) == '0);
  assign w_beat   = w_iter & out_ready;
  assign in_ready = ~w_iter | (w_beat & w_last);
  assign w_accept = in_valid & in_ready;

  // Beat fields are forced to zero outside ITER so idle outputs match the reset values.
  assign out_valid  = w_iter;
  assign out_onehot = w_iter ? w_pick : '0;
  assign out_index  = w_iter ? w_index : '0;
  assign out_last   = w_iter & w_last;
  assign out_empty  = w_iter & (r_remaining == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= SCREEN_JUNIOR;
      r_remaining <= '0;
    end else if (w_accept) begin
      // Also covers the last-beat reload: the new word replaces the finished one.
      r_state     <= ST_ITER;
      r_mode      <= screen_mode_t'(in_mode);
      r_remaining <= c_i ? in_word : '0;
    end else if (w_beat) begin
      r_remaining <= r_remaining & ~w_pick;
      if (w_last) begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: doc/screening_iterator.md
Name: screening_iterator

Overview:
- Sequential successor to the combinational priority screens.
- Accepts a word through a valid/ready handshake and emits its set bits one per beat as one-hot words plus binary index.
- Order is selectable per word: junior-first (LSB first) or senior-first (MSB first).
- Sits between request/flag registers and consumers that service one set bit at a time: interrupt dispatch, free-slot allocation, bit-serial scheduling.

Parameters:
- WORD_WIDTH, 8, width of input word and one-hot output; must be >= 2.
- INDEX_WIDTH, $clog2(WORD_WIDTH), width of out_index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_word/in_mode/c_i are valid.
- in_ready  output  1  block can accept a word this cycle.
- in_word  input  WORD_WIDTH  word to enumerate.
- in_mode  input  1  0 = junior-first, 1 = senior-first; latched with the word.
- c_i  input  1  screen enable; 0 makes the accepted word be treated as all-zero.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer takes the beat.
- out_onehot  output  WORD_WIDTH  current screened bit (one-hot, or zero on an empty beat).
- out_index  output  INDEX_WIDTH  bit position of out_onehot; 0 on an empty beat.
- out_last  output  1  final beat of the current word.
- out_empty  output  1  accepted word had no set bits, or c_i was 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: state = IDLE; remaining = 0; mode = 0; out_valid = 0; out_onehot = 0; out_index = 0; out_last = 0; out_empty = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation: rst_n = 0 in any state aborts the word. The in-flight beat is discarded and no further beats are emitted.
- State machine, two states:
  - IDLE: in_ready = 1, out_valid = 0.
  - ITER: out_valid = 1.
- Accept: in_valid & in_ready. Latch remaining = c_i ? in_word : 0 and mode = in_mode, then go to ITER.
- Latency: first beat visible the cycle after accept.
- Beat content in ITER, combinational from registers:
  - out_onehot = lowest set bit of remaining (mode 0) or highest set bit (mode 1).
  - out_index = encode(out_onehot).
  - out_last = (remaining & ~out_onehot) == 0.
  - out_empty = (remaining == 0).
- Empty word: exactly one beat with out_onehot = 0, out_index = 0, out_last = 1, out_empty = 1.
- Beat transfer: out_valid & out_ready. Update remaining &= ~out_onehot.
  - If out_last: go to IDLE, or reload if a new word is accepted the same cycle.
- Back-to-back: in_ready = (state == IDLE) | (out_valid & out_ready & out_last).
  - A word accepted on the last-beat cycle loads directly, staying in ITER with no bubble cycle.
- Backpressure: while out_valid & !out_ready, all out_* outputs and internal state hold stable. in_ready = 0 in that case.
- in_valid while busy is ignored (in_ready = 0); input data need not be held stable by the block.
- Throughput: one beat per cycle. A word with k set bits takes max(k,1) beats.
- All-ones word: WORD_WIDTH beats. Index wraps neither way; the last beat is at index WORD_WIDTH-1 (junior mode) or 0 (senior mode).

Decomposition:
- Package screening_pkg holds:
  - typedef enum logic {SCREEN_JUNIOR = 1'b0, SCREEN_SENIOR = 1'b1} screen_mode_t;
  - typedef enum logic {ST_IDLE, ST_ITER} screen_iter_state_t.
- Combinational screen: instantiate the existing screening_by_junior and screening_by_senior, both with c_i tied to 1, and mux their outputs on mode.
- One new sub-module: onehot_to_index, parameterised by WORD_WIDTH, a one-hot to binary encoder returning 0 for a zero input.

Test Plan:
1. Junior order (WORD_WIDTH = 8): in_word = 8'b1010_0110, in_mode = 0, c_i = 1, out_ready = 1 -> beats 8'h02/1, 8'h04/2, 8'h20/5, 8'h80/7. out_last only on the 4th beat; in_ready high again that cycle.
2. Senior order: same word, in_mode = 1 -> beats 8'h80/7, 8'h20/5, 8'h04/2, 8'h02/1 (last).
3. Empty cases: in_word = 8'h00 with c_i = 1, then in_word = 8'hFF with c_i = 0 -> each yields one beat with out_onehot = 0, out_index = 0, out_last = 1, out_empty = 1.
4. Backpressure: word 8'h11 in mode 0, out_ready low for 3 cycles after the first beat appears -> outputs stay at 8'h01/0 for 4 cycles with in_ready = 0. Then 8'h10/4 (last).
5. Back-to-back: in_valid held with 8'h03 then 8'h40 -> beats 8'h01, 8'h02 (last, 8'h40 accepted the same cycle), then 8'h40/6 on the very next cycle with no idle gap.
6. Reset mid-word: load 8'hF0 in mode 0, assert rst_n = 0 after the first beat -> the next cycle shows out_valid = 0, in_ready = 1, and no further beats of 8'hF0.
